// File: rtl/vnu_serial_sat.sv
// Serial saturating variable-node unit.
// Each frame takes the channel LLR followed by D check-to-variable messages over a
// valid/ready stream. It then emits D extrinsic messages q_i = l + sum(r) - r_i,
// saturated symmetrically to DATA_W bits, together with the hard decision.
module vnu_serial_sat #(
  parameter  int DATA_W = 6,
  parameter  int D      = 3,
  parameter  int EXT_W  = 3,
  localparam int IDX_W  = $clog2(D)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              dec,
  output logic              dec_valid
);

  localparam int SUM_W = DATA_W + EXT_W;
  localparam int CNT_W = $clog2(D + 1);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // Largest magnitude that may be emitted; the most negative code is never produced.
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(EXT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  // The accumulator must hold l plus D messages without wrapping.
  if (EXT_W < $clog2(D + 1)) begin : g_ext_w_check
    $error("vnu_serial_sat: EXT_W too small to hold the sum of D+1 messages");
  end

  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [SUM_W-1:0] r_sum;
  logic [DATA_W-1:0]       r_rbuf [D];
  logic                    r_dec;
  logic                    r_dec_valid;

  logic signed [SUM_W-1:0] w_sum_next;
  logic signed [SUM_W-1:0] w_diff;
  logic signed [SUM_W-1:0] w_sat;
  logic [CNT_W-1:0]        w_cnt_m1;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [IDX_W-1:0]        w_rd_idx;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_cnt_is_d;
  logic                    w_cnt_is_last;

  function automatic logic signed [SUM_W-1:0] sext(input logic [DATA_W-1:0] x);
    return {{EXT_W{x[DATA_W-1]}}, x};
  endfunction

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_EMIT);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  assign w_cnt_is_d    = (r_cnt == CNT_W'(D));
  assign w_cnt_is_last = (r_cnt == CNT_W'(D - 1));
  assign w_cnt_m1      = r_cnt - CNT_W'(1);
  assign w_wr_idx      = w_cnt_m1[IDX_W-1:0];
  assign w_rd_idx      = r_cnt[IDX_W-1:0];

  // Beat 0 seeds the accumulator with l; later beats add the incoming r.
  assign w_sum_next = (r_cnt == '0) ? sext(in_data) : (r_sum + sext(in_data));

  // Extrinsic value: the full sum minus this edge's own message (cannot overflow SUM_W).
  assign w_diff = r_sum - sext(r_rbuf[w_rd_idx]);

  // Symmetric clamp of the extrinsic value to the DATA_W range.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven so no latch is inferred.
    w_sat = w_diff;
    if (w_diff > SAT_MAX) begin
      w_sat = SAT_MAX;
    end else if (w_diff < SAT_MIN) begin
      w_sat = SAT_MIN;
    end
  end

  assign out_data  = w_sat[DATA_W-1:0];
  assign out_idx   = w_rd_idx;
  assign out_last  = out_valid & w_cnt_is_last;
  assign dec       = r_dec;
  assign dec_valid = r_dec_valid;

  // Frame sequencer: accumulate and buffer during LOAD, step through outputs during EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state updates use <= so every register samples pre-edge values.
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_dec       <= 1'b0;
      r_dec_valid <= 1'b0;
      // NOTE: the small message buffer is reset too, so a frame aborted by reset
      // leaves no stale messages behind.
      for (int i = 0; i < D; i++) begin
        r_rbuf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_sum <= w_sum_next;
            if (r_cnt != '0) begin
              r_rbuf[w_wr_idx] <= in_data;
            end
            if (w_cnt_is_d) begin
              r_state     <= S_EMIT;
              r_cnt       <= '0;
              r_dec       <= w_sum_next[SUM_W-1];
              r_dec_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (w_out_fire) begin
            if (w_cnt_is_last) begin
              r_state <= S_LOAD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vnu_serial_sat.sv
// Bench for vnu_serial_sat: randomized and directed frames, scoreboard queue filled
// by the stimulus side, and an independent monitor that compares on every output beat.
module tb_vnu_serial_sat;

  localparam int DATA_W = 6;
  localparam int D      = 3;
  localparam int EXT_W  = 3;
  localparam int IDX_W  = $clog2(D);
  localparam int QMAX   = 2 ** (DATA_W - 1) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              dec;
  logic              dec_valid;

  vnu_serial_sat #(.DATA_W(DATA_W), .D(D), .EXT_W(EXT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .dec       (dec),
    .dec_valid (dec_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  typedef int frame_t [D + 1];

  exp_t exp_q [$];
  bit   dec_q [$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode;      // 0: random out_ready, 1: always ready, 2: driven by the test
  bit   gaps_en;
  bit   has_dec;
  bit   exp_dec_cur;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic from the extrinsic-message definition.
  function automatic void push_frame(input frame_t v);
    int s;
    int q;
    s = 0;
    for (int i = 0; i <= D; i++) s += v[i];
    for (int i = 0; i < D; i++) begin
      q = s - v[i + 1];
      if (q > QMAX) q = QMAX;
      if (q < -QMAX) q = -QMAX;
      exp_q.push_back('{data: q, idx: i, last: (i == D - 1)});
    end
    dec_q.push_back(s < 0);
  endfunction

  // Drive one input beat; returns one cycle after it was accepted (posedge + 1 phase).
  task automatic send_beat(input int val);
    int budget;
    bit acc;
    budget = 0;
    acc    = 1'b0;
    if (gaps_en) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = val[DATA_W-1:0];
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    in_valid = 1'b0;
    if (!acc) check("in_accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input frame_t v);
    push_frame(v);
    for (int b = 0; b <= D; b++) send_beat(v[b]);
  endtask

  task automatic rand_frame();
    frame_t v;
    for (int b = 0; b <= D; b++) v[b] = int'($urandom_range(0, 63)) - 32;
    send_frame(v);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // out_ready generator for the random and always-ready modes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 1) out_ready = 1'b1;
    end
  end

  // Monitor: compares each output handshake against the scoreboard and checks
  // stall stability and the hard-decision hold during LOAD.
  initial begin
    bit   prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [IDX_W-1:0]  prev_idx;
    logic              prev_last;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", out_valid, 1);
          check("stall_data_held", $signed(out_data), $signed(prev_data));
          check("stall_idx_held", out_idx, prev_idx);
          check("stall_last_held", out_last, prev_last);
        end
        if (out_valid) begin
          check("in_ready_low_in_emit", in_ready, 0);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_output", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("q_data", $signed(out_data), e.data);
              check("q_idx", out_idx, e.idx);
              check("q_last", out_last, e.last);
              if (e.idx == 0 && dec_q.size() != 0) begin
                exp_dec_cur = dec_q.pop_front();
                has_dec     = 1'b1;
              end
              if (has_dec) begin
                check("dec_emit", dec, exp_dec_cur);
                check("dec_valid_emit", dec_valid, 1);
              end
            end
          end
        end else if (has_dec) begin
          check("dec_hold_load", dec, exp_dec_cur);
          check("dec_valid_hold_load", dec_valid, 1);
        end else begin
          check("dec_valid_idle", dec_valid, 0);
          check("dec_idle", dec, 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
        prev_last  = out_last;
      end
    end
  end

  // Stimulus and directed sequences.
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rdy_mode  = 1;
    gaps_en   = 1'b0;
    has_dec   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_dec", dec, 0);
    check("rst_dec_valid", dec_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic frame, then positive and negative saturation under random back-pressure.
    send_frame('{5, 2, -3, 4});
    wait_drain();
    rdy_mode = 0;
    send_frame('{31, 31, 31, 31});
    wait_drain();
    send_frame('{-32, -32, -32, -32});
    wait_drain();

    // Back-pressure: hold index 1 for three cycles.
    @(posedge clk);
    #1;
    rdy_mode  = 2;
    out_ready = 1'b0;
    send_frame('{5, 2, -3, 4});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_idx", out_idx, 1);
      check("bp_data", $signed(out_data), 11);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Input gaps and back-to-back frames, then a longer random run.
    rdy_mode = 0;
    gaps_en  = 1'b1;
    rand_frame();
    rand_frame();
    wait_drain();
    for (int f = 0; f < 30; f++) begin
      gaps_en = ($urandom_range(0, 1) == 1);
      rand_frame();
    end
    wait_drain();

    // Reset in the middle of EMIT after the index-0 handshake.
    @(posedge clk);
    #1;
    rdy_mode  = 1;
    out_ready = 1'b1;
    gaps_en   = 1'b0;
    send_frame('{1, 2, 3, 4});
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    has_dec = 1'b0;
    exp_q.delete();
    dec_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_dec_valid", dec_valid, 0);
    @(posedge clk);
    #1;
    send_frame('{1, 1, 1, 1});
    wait_drain();

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
